aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_key_expand.sv | 164 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128 on-the-fly key expansion: one round key per enabled cycle, with a combinational byte S-box.
// Optional round-key store is enabled by defining AES_KEY_STORE_EN.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, which also maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, x);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, x);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, x);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, x);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, x);
    return gf_mul(x127, x127);
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] cipher_key,
  input  logic         key_gene_en,
  output logic [127:0] round_key,
  output logic [3:0]   Round_Count,
  output logic         key_valid,
  output logic         done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state;
  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word, sub_word, temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic         advance;

  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  assign rot_word = {w3[23:0], w3[31:24]};

  aes_sbox sbox_3 (.in_byte(rot_word[31:24]), .out_byte(sub_word[31:24]));
  aes_sbox sbox_2 (.in_byte(rot_word[23:16]), .out_byte(sub_word[23:16]));
  aes_sbox sbox_1 (.in_byte(rot_word[15:8]),  .out_byte(sub_word[15:8]));
  aes_sbox sbox_0 (.in_byte(rot_word[7:0]),   .out_byte(sub_word[7:0]));

  assign temp     = sub_word ^ {rcon, 24'h000000};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // The count guard keeps Round_Count from passing NR even if the state were corrupted
  assign advance = (state == EXPAND) && key_gene_en && (Round_Count < 4'(NR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      round_key   <= '0;
      Round_Count <= '0;
      rcon        <= 8'h01;
      key_valid   <= 1'b0;
      done        <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (load) begin
        round_key   <= cipher_key;
        Round_Count <= '0;
        rcon        <= 8'h01;
        key_valid   <= 1'b1;
        done        <= 1'b0;
        state       <= EXPAND;
      end else begin
        case (state)
          IDLE: ;
          EXPAND: begin
            if (advance) begin
              round_key   <= next_key;
              Round_Count <= Round_Count + 4'd1;
              rcon        <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
              key_valid   <= 1'b1;
              if (Round_Count == 4'(NR - 1)) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef AES_KEY_STORE_EN
  // Entries are written alongside the round_key register so the store is readable with key_valid
  logic [127:0] key_store [0:10];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load)
        key_store[0] <= cipher_key;
      else if (advance)
        key_store[Round_Count + 4'd1] <= next_key;
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_addr <= 4'd10)
      rd_key = key_store[rd_addr];
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand using the FIPS-197 AES-128 key schedule vectors.
// Store reads are checked only when AES_KEY_STORE_EN is defined.

module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [127:0] cipher_key;
  logic         key_gene_en;
  logic [127:0] round_key;
  logic [3:0]   Round_Count;
  logic         key_valid;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
`endif

  aes_key_expand #(.NR(10)) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .cipher_key(cipher_key),
    .key_gene_en(key_gene_en),
    .round_key(round_key),
    .Round_Count(Round_Count),
    .key_valid(key_valid),
    .done(done)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_addr(rd_addr),
    .rd_key(rd_key)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KA [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] KZ1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ2 = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

  typedef struct packed {
    logic [3:0]   cnt;
    logic [127:0] key;
    logic         dn;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic [127:0] k, input logic en, input logic r);
    load        = l;
    cipher_key  = k;
    key_gene_en = en;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int cnt, input logic [127:0] key, input logic dn);
    exp_t e;
    e.cnt = 4'(cnt);
    e.key = key;
    e.dn  = dn;
    sb_q.push_back(e);
  endtask

  // Monitor: every key_valid pulse must match the oldest expected round key
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_key_valid: got count %0d key %h required no pulse", Round_Count, round_key);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("sb_round_count", 128'(Round_Count), 128'(mon_e.cnt));
        checkOutput("sb_round_key", round_key, mon_e.key);
        checkOutput("sb_done", 128'(done), 128'(mon_e.dn));
      end
    end
  end

  initial begin
    int k;
    logic [3:0] pat;
    logic en;
    rst = 1'b1; load = 1'b0; key_gene_en = 1'b0; cipher_key = '0;
`ifdef AES_KEY_STORE_EN
    rd_addr = 4'd0;
`endif
    $display("[TB] start");

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("reset_round_key", round_key, '0);
    checkOutput("reset_round_count", 128'(Round_Count), 128'd0);
    checkOutput("reset_key_valid", 128'(key_valid), 128'd0);
    checkOutput("reset_done", 128'(done), 128'd0);

    // Enable without load in IDLE must not advance
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, KA[0], 1'b1, 1'b0);
      checkOutput("idle_key_valid", 128'(key_valid), 128'd0);
      checkOutput("idle_round_count", 128'(Round_Count), 128'd0);
    end

    // Continuous expansion; load wins over simultaneous enable
    pushExp(0, KA[0], 1'b0);
    applyStimulus(1'b1, KA[0], 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      pushExp(i, KA[i], i == 10);
      applyStimulus(1'b0, KA[0], 1'b1, 1'b0);
      checkOutput("cont_done_timing", 128'(done), (i == 10) ? 128'd1 : 128'd0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, KA[0], 1'b1, 1'b0);
      checkOutput("done_hold_key_valid", 128'(key_valid), 128'd0);
      checkOutput("done_hold_count", 128'(Round_Count), 128'd10);
      checkOutput("done_hold_key", round_key, KA[10]);
      checkOutput("done_hold_done", 128'(done), 128'd1);
    end

`ifdef AES_KEY_STORE_EN
    rd_addr = 4'd0;  #1 checkOutput("store_rd0", rd_key, KA[0]);
    rd_addr = 4'd5;  #1 checkOutput("store_rd5", rd_key, KA[5]);
    rd_addr = 4'd10; #1 checkOutput("store_rd10", rd_key, KA[10]);
    rd_addr = 4'd15; #1 checkOutput("store_rd15", rd_key, '0);
`endif

    // Toggled enable 1,0,0,1: outputs must hold during stalls
    pat = 4'b1001;
    k = 0;
    pushExp(0, KA[0], 1'b0);
    applyStimulus(1'b1, KA[0], 1'b0, 1'b0);
    for (int c = 0; c < 40 && k < 10; c++) begin
      en = pat[c % 4];
      if (en) begin
        k++;
        pushExp(k, KA[k], k == 10);
      end
      applyStimulus(1'b0, KA[0], en, 1'b0);
      if (!en) begin
        checkOutput("stall_key_valid", 128'(key_valid), 128'd0);
        checkOutput("stall_round_key", round_key, KA[k]);
        checkOutput("stall_round_count", 128'(Round_Count), 128'(k));
      end
    end
    checkOutput("toggle_final_done", 128'(done), 128'd1);
    checkOutput("toggle_final_key", round_key, KA[10]);

    // Reload with the zero key at Round_Count=5
    pushExp(0, KA[0], 1'b0);
    applyStimulus(1'b1, KA[0], 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      pushExp(i, KA[i], 1'b0);
      applyStimulus(1'b0, KA[0], 1'b1, 1'b0);
    end
    pushExp(0, '0, 1'b0);
    applyStimulus(1'b1, '0, 1'b1, 1'b0);
    checkOutput("reload_count", 128'(Round_Count), 128'd0);
    checkOutput("reload_done", 128'(done), 128'd0);
    pushExp(1, KZ1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    pushExp(2, KZ2, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Reset at Round_Count=4 with enable high abandons expansion
    pushExp(0, KA[0], 1'b0);
    applyStimulus(1'b1, KA[0], 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      pushExp(i, KA[i], 1'b0);
      applyStimulus(1'b0, KA[0], 1'b1, 1'b0);
    end
    applyStimulus(1'b0, KA[0], 1'b1, 1'b1);
    checkOutput("midrst_round_key", round_key, '0);
    checkOutput("midrst_count", 128'(Round_Count), 128'd0);
    checkOutput("midrst_key_valid", 128'(key_valid), 128'd0);
    checkOutput("midrst_done", 128'(done), 128'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, KA[0], 1'b1, 1'b0);
      checkOutput("postrst_key_valid", 128'(key_valid), 128'd0);
      checkOutput("postrst_count", 128'(Round_Count), 128'd0);
    end

    // Simultaneous reset and load: reset wins
    pushExp(0, KA[0], 1'b0);
    applyStimulus(1'b1, KA[0], 1'b0, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      pushExp(i, KA[i], 1'b0);
      applyStimulus(1'b0, KA[0], 1'b1, 1'b0);
    end
    applyStimulus(1'b1, KA[0], 1'b1, 1'b1);
    checkOutput("rstload_key_valid", 128'(key_valid), 128'd0);
    checkOutput("rstload_round_key", round_key, '0);
    checkOutput("rstload_count", 128'(Round_Count), 128'd0);
    checkOutput("rstload_done", 128'(done), 128'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, KA[0], 1'b1, 1'b0);
      checkOutput("rstload_idle_key_valid", 128'(key_valid), 128'd0);
    end

    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("scoreboard_drained", 128'(sb_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
